// File: rtl/rgb_pixel_packer.sv
// rgb_pixel_packer: packs 24-bit RGB pixels into a 32-bit AXI4-Stream.
// Four accepted pixels (12 bytes) become three words, earliest byte in
// tdata[7:0]. sof resynchronises the group and marks W0 with tuser; eol on
// the fourth pixel of a group marks W2 with tlast.
//
// Handshake: a pixel moves when valid && in_stream_ready; a word moves when
// out_stream_tvalid && out_stream_tready. The input is ready whenever the
// output register is empty or being drained this cycle, so every accepted
// pixel always has room for the (at most one) word it produces.
module rgb_pixel_packer (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [7:0]  r,
   input  logic [7:0]  g,
   input  logic [7:0]  b,
   input  logic        valid,
   input  logic        sof,
   input  logic        eol,
   output logic        in_stream_ready,
   output logic [31:0] out_stream_tdata,
   output logic [3:0]  out_stream_tkeep,
   output logic        out_stream_tlast,
   output logic        out_stream_tuser,
   output logic        out_stream_tvalid,
   input  logic        out_stream_tready
);

   // Position of the next pixel inside its 4-pixel group.
   logic [1:0]  phase;
   // Bytes carried over between pixels of a group, earliest byte in [7:0].
   logic [23:0] hold;
   // sof seen on P0 of the current group, pending for its W0.
   logic        sof_pend;

   logic        accept;
   logic [1:0]  eff_phase;
   logic        emit;
   logic [31:0] word;
   logic        word_last;
   logic        word_user;

   assign in_stream_ready  = !out_stream_tvalid || out_stream_tready;
   assign accept           = valid && in_stream_ready;
   // A sof pixel always starts a fresh group, discarding any partial bytes.
   assign eff_phase        = sof ? 2'd0 : phase;
   assign out_stream_tkeep = 4'hF;

   // Word assembly for the incoming pixel at its effective phase.
   always_comb begin
      emit      = 1'b0;
      word      = 32'h0;
      word_last = 1'b0;
      word_user = 1'b0;
      case (eff_phase)
         2'd1: begin
            emit      = 1'b1;
            word      = {r, hold[23:0]};
            word_user = sof_pend;
         end
         2'd2: begin
            emit = 1'b1;
            word = {g, r, hold[15:0]};
         end
         2'd3: begin
            emit      = 1'b1;
            word      = {b, g, r, hold[7:0]};
            word_last = eol;
         end
         default: begin
            emit = 1'b0;
         end
      endcase
   end

   // Group state: phase counter, leftover bytes and pending sof.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         phase    <= 2'd0;
         hold     <= 24'h0;
         sof_pend <= 1'b0;
      end else if (accept) begin
         phase <= eff_phase + 2'd1;
         case (eff_phase)
            2'd0: begin
               hold     <= {b, g, r};
               sof_pend <= sof;
            end
            2'd1: begin
               hold     <= {8'h00, b, g};
               sof_pend <= 1'b0;
            end
            2'd2: begin
               hold <= {16'h0000, b};
            end
            default: begin
               hold <= 24'h0;
            end
         endcase
      end
   end

   // Output register: load on an emitting accept, otherwise drain on tready.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         out_stream_tvalid <= 1'b0;
         out_stream_tdata  <= 32'h0;
         out_stream_tlast  <= 1'b0;
         out_stream_tuser  <= 1'b0;
      end else if (accept && emit) begin
         out_stream_tvalid <= 1'b1;
         out_stream_tdata  <= word;
         out_stream_tlast  <= word_last;
         out_stream_tuser  <= word_user;
      end else if (out_stream_tready) begin
         out_stream_tvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rgb_pixel_packer.sv
// Testbench for rgb_pixel_packer: directed scenario tasks plus a randomized
// run, with a byte-queue reference model feeding an expected-word queue.
module tb_rgb_pixel_packer;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [7:0]  r, g, b;
   logic        valid, sof, eol;
   logic        in_stream_ready;
   logic [31:0] out_stream_tdata;
   logic [3:0]  out_stream_tkeep;
   logic        out_stream_tlast;
   logic        out_stream_tuser;
   logic        out_stream_tvalid;
   logic        out_stream_tready;

   int tests_run    = 0;
   int tests_failed = 0;

   // Expected words: {tuser, tlast, tdata}.
   logic [33:0] exp_q[$];
   // Bytes of the current group in stream order.
   logic [7:0]  grp_bytes[$];
   bit          grp_sof;
   bit          rand_done;

   rgb_pixel_packer dut (
      .aclk              (aclk),
      .aresetn           (aresetn),
      .r                 (r),
      .g                 (g),
      .b                 (b),
      .valid             (valid),
      .sof               (sof),
      .eol               (eol),
      .in_stream_ready   (in_stream_ready),
      .out_stream_tdata  (out_stream_tdata),
      .out_stream_tkeep  (out_stream_tkeep),
      .out_stream_tlast  (out_stream_tlast),
      .out_stream_tuser  (out_stream_tuser),
      .out_stream_tvalid (out_stream_tvalid),
      .out_stream_tready (out_stream_tready)
   );

   // Clock.
   always #5 aclk = ~aclk;

   // Watchdog.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: the group is a byte list; word n of the group is
   // bytes [4n..4n+3], available once the byte list holds 4n+4 bytes.
   task automatic model_accept(input logic [7:0] pr, pg, pb, input logic ps, pe);
      int k, n;
      logic [31:0] w;
      if (ps) begin
         grp_bytes.delete();
         grp_sof = 1'b1;
      end
      grp_bytes.push_back(pr);
      grp_bytes.push_back(pg);
      grp_bytes.push_back(pb);
      k = grp_bytes.size() / 3;
      if (k >= 2) begin
         n = k - 2;
         w = {grp_bytes[4*n+3], grp_bytes[4*n+2], grp_bytes[4*n+1], grp_bytes[4*n]};
         exp_q.push_back({(grp_sof && n == 0), (pe && k == 4), w});
      end
      if (k == 4) begin
         grp_bytes.delete();
         grp_sof = 1'b0;
      end
   endtask

   // Scoreboard and model feed, sampled half a cycle before each edge.
   always @(negedge aclk) begin
      logic [33:0] exp;
      if (aresetn === 1'b1) begin
         tests_run++;
         if (in_stream_ready !== (!out_stream_tvalid || out_stream_tready)) begin
            tests_failed++;
            $display("FAIL ready_rule: in_stream_ready=%b tvalid=%b tready=%b",
                     in_stream_ready, out_stream_tvalid, out_stream_tready);
         end
         if (out_stream_tvalid && out_stream_tready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               tests_failed++;
               $display("FAIL unexpected_word: got tdata=%h with no word expected", out_stream_tdata);
            end else begin
               exp = exp_q.pop_front();
               if ({out_stream_tuser, out_stream_tlast, out_stream_tdata} !== exp ||
                   out_stream_tkeep !== 4'hF) begin
                  tests_failed++;
                  $display("FAIL word: got user=%b last=%b data=%h keep=%h, expected user=%b last=%b data=%h keep=f",
                           out_stream_tuser, out_stream_tlast, out_stream_tdata, out_stream_tkeep,
                           exp[33], exp[32], exp[31:0]);
               end
            end
         end
         if (valid && in_stream_ready)
            model_accept(r, g, b, sof, eol);
      end
   end

   // Driver: present a pixel from posedge+1 and hold it until accepted.
   task automatic send_pixel(input logic [7:0] pr, pg, pb, input logic ps, pe);
      int n = 0;
      r = pr; g = pg; b = pb; sof = ps; eol = pe; valid = 1'b1;
      @(negedge aclk);
      while (!in_stream_ready && n < 200) begin
         @(negedge aclk);
         n++;
      end
      if (n >= 200) begin
         tests_run++;
         tests_failed++;
         $display("FAIL send_timeout: in_stream_ready=%b, required 1 within 200 cycles", in_stream_ready);
      end
      @(posedge aclk);
      #1;
      valid = 1'b0; sof = 1'b0; eol = 1'b0;
   endtask

   // Driver: assert reset asynchronously, flush the model, release later.
   task automatic apply_reset();
      aresetn = 1'b0;
      exp_q.delete();
      grp_bytes.delete();
      grp_sof = 1'b0;
      #1;
   endtask

   task automatic release_reset();
      @(negedge aclk);
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      tests_run++;
      if (out_stream_tvalid !== 1'b0 || out_stream_tdata !== 32'h0 ||
          out_stream_tlast !== 1'b0 || out_stream_tuser !== 1'b0 || in_stream_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s: tvalid=%b tdata=%h tlast=%b tuser=%b ready=%b, required 0 0 0 0 1",
                  tag, out_stream_tvalid, out_stream_tdata, out_stream_tlast, out_stream_tuser, in_stream_ready);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      check_reset_outputs("reset_state");
      tests_run++;
      if (out_stream_tkeep !== 4'hF) begin
         tests_failed++;
         $display("FAIL reset_tkeep: got %h, required f", out_stream_tkeep);
      end
      release_reset();
   endtask

   task automatic test_basic();
      send_pixel(8'h01, 8'h02, 8'h03, 1'b1, 1'b0);
      tests_run++;
      if (out_stream_tvalid !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_p0_no_word: tvalid=%b, required 0", out_stream_tvalid);
      end
      send_pixel(8'h04, 8'h05, 8'h06, 1'b0, 1'b0);
      tests_run++;
      if ({out_stream_tvalid, out_stream_tuser, out_stream_tlast, out_stream_tdata} !== {3'b110, 32'h04030201}) begin
         tests_failed++;
         $display("FAIL basic_w0: valid=%b user=%b last=%b data=%h, required 1 1 0 04030201",
                  out_stream_tvalid, out_stream_tuser, out_stream_tlast, out_stream_tdata);
      end
      send_pixel(8'h07, 8'h08, 8'h09, 1'b0, 1'b0);
      tests_run++;
      if ({out_stream_tvalid, out_stream_tuser, out_stream_tlast, out_stream_tdata} !== {3'b100, 32'h08070605}) begin
         tests_failed++;
         $display("FAIL basic_w1: valid=%b user=%b last=%b data=%h, required 1 0 0 08070605",
                  out_stream_tvalid, out_stream_tuser, out_stream_tlast, out_stream_tdata);
      end
      send_pixel(8'h0A, 8'h0B, 8'h0C, 1'b0, 1'b1);
      tests_run++;
      if ({out_stream_tvalid, out_stream_tuser, out_stream_tlast, out_stream_tdata, out_stream_tkeep} !==
          {3'b101, 32'h0C0B0A09, 4'hF}) begin
         tests_failed++;
         $display("FAIL basic_w2: valid=%b user=%b last=%b data=%h keep=%h, required 1 0 1 0c0b0a09 f",
                  out_stream_tvalid, out_stream_tuser, out_stream_tlast, out_stream_tdata, out_stream_tkeep);
      end
   endtask

   task automatic test_backpressure();
      send_pixel(8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
      send_pixel(8'h04, 8'h05, 8'h06, 1'b0, 1'b0);
      out_stream_tready = 1'b0;
      r = 8'h07; g = 8'h08; b = 8'h09; sof = 1'b0; eol = 1'b0; valid = 1'b1;
      repeat (3) begin
         @(negedge aclk);
         tests_run++;
         if (in_stream_ready !== 1'b0 || out_stream_tvalid !== 1'b1 || out_stream_tdata !== 32'h04030201) begin
            tests_failed++;
            $display("FAIL bp_hold: ready=%b tvalid=%b tdata=%h, required 0 1 04030201",
                     in_stream_ready, out_stream_tvalid, out_stream_tdata);
         end
      end
      @(posedge aclk);
      #1;
      out_stream_tready = 1'b1;
      send_pixel(8'h07, 8'h08, 8'h09, 1'b0, 1'b0);
      tests_run++;
      if (out_stream_tvalid !== 1'b1 || out_stream_tdata !== 32'h08070605) begin
         tests_failed++;
         $display("FAIL bp_w1: tvalid=%b tdata=%h, required 1 08070605", out_stream_tvalid, out_stream_tdata);
      end
      send_pixel(8'h0A, 8'h0B, 8'h0C, 1'b0, 1'b0);
      tests_run++;
      if (out_stream_tdata !== 32'h0C0B0A09 || out_stream_tlast !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_w2: tdata=%h tlast=%b, required 0c0b0a09 0", out_stream_tdata, out_stream_tlast);
      end
   endtask

   task automatic test_eol();
      send_pixel(8'h21, 8'h22, 8'h23, 1'b0, 1'b0);
      send_pixel(8'h24, 8'h25, 8'h26, 1'b0, 1'b1);
      tests_run++;
      if (out_stream_tlast !== 1'b0 || out_stream_tdata !== 32'h24232221) begin
         tests_failed++;
         $display("FAIL eol_p1_ignored: tlast=%b tdata=%h, required 0 24232221", out_stream_tlast, out_stream_tdata);
      end
      send_pixel(8'h27, 8'h28, 8'h29, 1'b0, 1'b0);
      send_pixel(8'h2A, 8'h2B, 8'h2C, 1'b0, 1'b1);
      tests_run++;
      if (out_stream_tlast !== 1'b1 || out_stream_tdata !== 32'h2C2B2A29) begin
         tests_failed++;
         $display("FAIL eol_p3: tlast=%b tdata=%h, required 1 2c2b2a29", out_stream_tlast, out_stream_tdata);
      end
   endtask

   task automatic test_sof_resync();
      send_pixel(8'h11, 8'h12, 8'h13, 1'b0, 1'b0);
      send_pixel(8'h14, 8'h15, 8'h16, 1'b0, 1'b0);
      send_pixel(8'hAA, 8'hBB, 8'hCC, 1'b1, 1'b1);
      tests_run++;
      if (out_stream_tvalid !== 1'b0) begin
         tests_failed++;
         $display("FAIL sof_p0_no_word: tvalid=%b, required 0", out_stream_tvalid);
      end
      send_pixel(8'hDD, 8'hEE, 8'hFF, 1'b0, 1'b0);
      tests_run++;
      if (out_stream_tdata !== 32'hDDCCBBAA || out_stream_tuser !== 1'b1 || out_stream_tlast !== 1'b0) begin
         tests_failed++;
         $display("FAIL sof_w0: tdata=%h tuser=%b tlast=%b, required ddccbbaa 1 0",
                  out_stream_tdata, out_stream_tuser, out_stream_tlast);
      end
      send_pixel(8'h31, 8'h32, 8'h33, 1'b0, 1'b0);
      tests_run++;
      if (out_stream_tdata !== 32'h3231FFEE || out_stream_tuser !== 1'b0) begin
         tests_failed++;
         $display("FAIL sof_w1: tdata=%h tuser=%b, required 3231ffee 0", out_stream_tdata, out_stream_tuser);
      end
      send_pixel(8'h34, 8'h35, 8'h36, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid_group();
      send_pixel(8'h41, 8'h42, 8'h43, 1'b0, 1'b0);
      send_pixel(8'h44, 8'h45, 8'h46, 1'b0, 1'b0);
      apply_reset();
      check_reset_outputs("reset_mid_group");
      release_reset();
      send_pixel(8'h51, 8'h52, 8'h53, 1'b0, 1'b0);
      send_pixel(8'h54, 8'h55, 8'h56, 1'b0, 1'b0);
      tests_run++;
      if (out_stream_tdata !== 32'h54535251 || out_stream_tuser !== 1'b0 || out_stream_tvalid !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_repack_w0: tdata=%h tuser=%b tvalid=%b, required 54535251 0 1",
                  out_stream_tdata, out_stream_tuser, out_stream_tvalid);
      end
      send_pixel(8'h57, 8'h58, 8'h59, 1'b0, 1'b0);
      send_pixel(8'h5A, 8'h5B, 8'h5C, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      rand_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 400; i++) begin
               int gap;
               gap = $urandom_range(0, 2);
               repeat (gap) begin
                  @(posedge aclk);
                  #1;
               end
               send_pixel(8'($urandom), 8'($urandom), 8'($urandom),
                          ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge aclk);
               #1;
               out_stream_tready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_stream_tready = 1'b1;
      repeat (4) begin
         @(posedge aclk);
         #1;
      end
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL drain: %0d expected words never appeared, required 0", exp_q.size());
      end
   endtask

   initial begin
      aresetn = 1'b0;
      r = 8'h0; g = 8'h0; b = 8'h0;
      valid = 1'b0; sof = 1'b0; eol = 1'b0;
      out_stream_tready = 1'b1;
      grp_sof = 1'b0;
      rand_done = 1'b0;
      #12;
      test_reset();
      test_basic();
      test_backpressure();
      test_eol();
      test_sof_resync();
      test_reset_mid_group();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
